// File: rtl/incrementor_seq.sv
// Sequential incrementor: adds `steps` to `inp` one +1 per cycle, with sticky overflow flag.
// Optional build macro INCREMENTOR_SATURATE_EN clamps the accumulator at all-ones instead of wrapping.
module incrementor_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp,
    input  logic [WIDTH-1:0] steps,
    output logic [WIDTH-1:0] o,
    output logic             carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;

    function automatic logic [WIDTH-1:0] inc_acc(input logic [WIDTH-1:0] a);
`ifdef INCREMENTOR_SATURATE_EN
        return (a == MAX_VAL) ? MAX_VAL : a + 1'b1;
`else
        return a + 1'b1;
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = inp;
                    cnt_d   = steps;
                    carry_d = 1'b0;
                    state_d = (steps != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // Overflow is flagged on the attempt, whether the build wraps or saturates.
                acc_d   = inc_acc(acc_q);
                carry_d = carry_q | (acc_q == MAX_VAL);
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All handshake outputs decode registered state only, so no input-to-output paths exist.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign o         = acc_q;
    assign carry     = carry_q;

endmodule
